fft_peak_picker: RTL and testbench

- Upstream neighbour of the frequency estimator.
- Consumes one FFT frame of per-bin magnitude/phase samples and finds the strongest bin inside a search window.
- Presents that bin's index and phase as stable registers, then pulses the estimator's start and waits for its done.
- Frames that finish while the estimator is busy are discarded and flagged.

---
 rtl/fft_peak_picker.sv | 115 +++++++++++
 tb/tb_fft_peak_picker.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_picker.sv
// FFT peak picker: scans each frame for the strongest in-window bin
// and launches the frequency estimator on it when the estimator is free.
module fft_peak_picker #(
  parameter logic [8:0]  MIN_BIN    = 9'd1,
  parameter logic [8:0]  MAX_BIN    = 9'd255,
  parameter logic [31:0] MAG_THRESH = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bin_valid,
  input  logic [8:0]  bin_index,
  input  logic [31:0] bin_mag,
  input  logic [31:0] bin_phase,
  input  logic        bin_last,
  input  logic        est_done,
  output logic        est_start,
  output logic [8:0]  max_index,
  output logic [31:0] max_phase,
  output logic        peak_valid,
  output logic        overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic        est_start_q;
  logic [8:0]  max_index_q;
  logic [31:0] max_phase_q;
  logic        peak_valid_q;
  logic        overrun_q;

  logic [31:0] best_mag_q;
  logic [8:0]  best_idx_q;
  logic [31:0] best_ph_q;
  logic        found_q;

  logic        in_win;
  logic        take;
  logic        fin_found;
  logic [31:0] fin_mag;
  logic [8:0]  fin_idx;
  logic [31:0] fin_ph;
  logic        frame_end;
  logic        launch;
  logic        drop;

  // Merge the current bin into the running best to form the final peak
  always_comb begin
    in_win    = (bin_index >= MIN_BIN) && (bin_index <= MAX_BIN);
    take      = bin_valid && in_win &&
                (!found_q || (bin_mag > best_mag_q));
    fin_found = found_q || (bin_valid && in_win);
    fin_mag   = take ? bin_mag   : best_mag_q;
    fin_idx   = take ? bin_index : best_idx_q;
    fin_ph    = take ? bin_phase : best_ph_q;
    frame_end = bin_valid && bin_last;
    launch    = frame_end && (state_q == IDLE) && est_done &&
                fin_found && (fin_mag >= MAG_THRESH);
    drop      = frame_end && ((state_q == RUN) || !est_done);
  end

  // Running peak scan; cleared at frame end so the next frame starts clean
  always_ff @(posedge clk) begin
    if (rst || frame_end) begin
      best_mag_q <= '0;
      best_idx_q <= '0;
      best_ph_q  <= '0;
      found_q    <= 1'b0;
    end else if (bin_valid) begin
      best_mag_q <= fin_mag;
      best_idx_q <= fin_idx;
      best_ph_q  <= fin_ph;
      found_q    <= fin_found;
    end
  end

  // Launch/run control; peak outputs only move on a launch edge from IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      est_start_q  <= 1'b0;
      max_index_q  <= '0;
      max_phase_q  <= '0;
      peak_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      est_start_q <= 1'b0;
      if (drop)
        overrun_q <= 1'b1;
      unique case (state_q)
        IDLE: begin
          if (launch) begin
            max_index_q  <= fin_idx;
            max_phase_q  <= fin_ph;
            peak_valid_q <= 1'b1;
            est_start_q  <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (est_done && !est_start_q)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign est_start  = est_start_q;
  assign max_index  = max_index_q;
  assign max_phase  = max_phase_q;
  assign peak_valid = peak_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_fft_peak_picker.sv
// Bench for fft_peak_picker: frame-level model plus directed frames
// with literal expectations on the launched peak.
module tb_fft_peak_picker;

  localparam logic [31:0] THRESH = 32'h0001_0000;
  localparam int          WLO    = 1;
  localparam int          WHI    = 255;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bin_valid = 1'b0;
  logic [8:0]  bin_index = '0;
  logic [31:0] bin_mag = '0;
  logic [31:0] bin_phase = '0;
  logic        bin_last = 1'b0;
  logic        est_done = 1'b1;
  logic        est_start;
  logic [8:0]  max_index;
  logic [31:0] max_phase;
  logic        peak_valid;
  logic        overrun;

  fft_peak_picker dut (
    .clk       (clk),
    .rst       (rst),
    .bin_valid (bin_valid),
    .bin_index (bin_index),
    .bin_mag   (bin_mag),
    .bin_phase (bin_phase),
    .bin_last  (bin_last),
    .est_done  (est_done),
    .est_start (est_start),
    .max_index (max_index),
    .max_phase (max_phase),
    .peak_valid(peak_valid),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp,
               $time);
    end
  endfunction

  // ---------------- frame-level model ----------------
  typedef struct {
    int          idx;
    logic [31:0] mag;
    logic [31:0] ph;
  } bin_t;

  bin_t        fq[$];
  bit          m_start, m_busy, m_pv, m_ov;
  int          m_idx;
  logic [31:0] m_ph;

  bit          pf;
  logic [31:0] pmax;
  int          pidx;
  logic [31:0] pph;
  bit          ns, busy_now, started;

  task automatic frame_peak();
    pf = 0;
    pmax = 0;
    pidx = 0;
    pph = 0;
    foreach (fq[k])
      if (fq[k].idx >= WLO && fq[k].idx <= WHI) begin
        if (!pf || fq[k].mag > pmax) pmax = fq[k].mag;
        pf = 1;
      end
    for (int k = fq.size() - 1; k >= 0; k--)
      if (fq[k].idx >= WLO && fq[k].idx <= WHI && fq[k].mag == pmax) begin
        pidx = fq[k].idx;
        pph  = fq[k].ph;
      end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      m_start = 0;
      m_busy  = 0;
      m_pv    = 0;
      m_ov    = 0;
      m_idx   = 0;
      m_ph    = 0;
    end else begin
      ns       = 0;
      busy_now = m_busy;
      started  = m_start;
      if (bin_valid) begin
        fq.push_back('{int'(bin_index), bin_mag, bin_phase});
        if (bin_last) begin
          frame_peak();
          if (busy_now || !est_done) m_ov = 1;
          else if (pf && pmax >= THRESH) begin
            m_idx  = pidx;
            m_ph   = pph;
            m_pv   = 1;
            ns     = 1;
            m_busy = 1;
          end
          fq.delete();
        end
      end
      if (busy_now && !started && est_done) m_busy = 0;
      m_start = ns;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("est_start",  32'(est_start),  32'(m_start));
      chk("max_index",  32'(max_index),  32'(m_idx));
      chk("max_phase",  max_phase,       m_ph);
      chk("peak_valid", 32'(peak_valid), 32'(m_pv));
      chk("overrun",    32'(overrun),    32'(m_ov));
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] mag_a [512];
  logic [31:0] ph_a  [512];

  task automatic fill(input logic [31:0] m);
    for (int i = 0; i < 512; i++) begin
      mag_a[i] = m;
      ph_a[i]  = 32'(i) * 32'h0000_1111;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bin_valid = 1'b0;
    bin_last = 1'b0;
    cyc(2);
    rst = 1'b0;
  endtask

  // Returns #1 into the cycle after the last bin
  task automatic send_frame(input int n, input int gap, input bit last);
    for (int i = 0; i < n; i++) begin
      if (gap > 0 && (i % gap) == 3) begin
        @(posedge clk); #1;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
      end
      @(posedge clk); #1;
      bin_valid = 1'b1;
      bin_index = 9'(i);
      bin_mag   = mag_a[i];
      bin_phase = ph_a[i];
      bin_last  = last && (i == n - 1);
    end
    @(posedge clk); #1;
    bin_valid = 1'b0;
    bin_last  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_en = 1;
    chk("rst_index", 32'(max_index), 32'd0);
    chk("rst_pv", 32'(peak_valid), 32'd0);
    chk("rst_ovr", 32'(overrun), 32'd0);

    // Peak at 40 in a ramp; ramp above 255 is outside the window
    for (int i = 0; i < 512; i++) begin
      mag_a[i] = 32'(i) * 32'h100;
      ph_a[i]  = 32'(i);
    end
    mag_a[40] = 32'h0050_0000;
    ph_a[40]  = 32'h0012_3456;
    send_frame(512, 37, 1);
    chk("t1_start", 32'(est_start), 32'd1);
    chk("t1_index", 32'(max_index), 32'd40);
    chk("t1_phase", max_phase, 32'h0012_3456);
    chk("t1_pv", 32'(peak_valid), 32'd1);
    cyc(1);
    chk("t1_pulse", 32'(est_start), 32'd0);
    cyc(4);

    // Huge bins only outside the window
    do_reset();
    fill(32'h0);
    mag_a[0]   = 32'hFFFF_FFFF;
    mag_a[300] = 32'hFFFF_FFFF;
    send_frame(512, 0, 1);
    chk("t2_start", 32'(est_start), 32'd0);
    chk("t2_index", 32'(max_index), 32'd0);
    chk("t2_phase", max_phase, 32'd0);
    cyc(4);

    // Tie keeps the earlier bin
    fill(32'h0);
    mag_a[10] = 32'h0020_0000;
    mag_a[20] = 32'h0020_0000;
    send_frame(256, 0, 1);
    chk("t3_index", 32'(max_index), 32'd10);
    chk("t3_phase", max_phase, 32'h0000_AAAA);
    cyc(4);

    // Everything below threshold
    do_reset();
    fill(32'h0000_8000);
    send_frame(256, 11, 1);
    chk("t4_start", 32'(est_start), 32'd0);
    chk("t4_pv", 32'(peak_valid), 32'd0);
    cyc(4);

    // Window edges: bin 255 counts, bin 256 does not
    fill(32'h0);
    mag_a[255] = 32'h0003_0000;
    send_frame(260, 0, 1);
    chk("edge_hi", 32'(max_index), 32'd255);
    cyc(4);
    fill(32'h0);
    mag_a[1]   = 32'h0002_0000;
    mag_a[256] = 32'h0009_0000;
    send_frame(260, 0, 1);
    chk("edge_lo", 32'(max_index), 32'd1);
    cyc(4);

    // Overrun while estimator busy
    do_reset();
    fill(32'h0);
    mag_a[50] = 32'h0004_0000;
    send_frame(256, 0, 1);
    est_done = 1'b0;
    chk("t5_a_index", 32'(max_index), 32'd50);
    fill(32'h0);
    mag_a[100] = 32'h0008_0000;
    send_frame(256, 0, 1);
    chk("t5_ovr", 32'(overrun), 32'd1);
    chk("t5_keep", 32'(max_index), 32'd50);
    cyc(2000 - 258);
    est_done = 1'b1;
    cyc(4);
    fill(32'h0);
    mag_a[77] = 32'h0006_0000;
    send_frame(256, 0, 1);
    chk("t5_c_start", 32'(est_start), 32'd1);
    chk("t5_c_index", 32'(max_index), 32'd77);
    chk("t5_c_ovr", 32'(overrun), 32'd1);
    cyc(4);

    // Reset mid-frame discards the partial frame
    fill(32'h0);
    mag_a[30] = 32'hF000_0000;
    send_frame(41, 0, 0);
    do_reset();
    fill(32'h0);
    mag_a[60] = 32'h0007_0000;
    send_frame(256, 0, 1);
    chk("t6_index", 32'(max_index), 32'd60);
    chk("t6_ovr", 32'(overrun), 32'd0);
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
